// File: rtl/spi_slave_byte.sv
// ---------------------------------------------------------------------------
// spi_slave_byte
//
// Byte-oriented SPI slave. The external n_cs/sclk/mosi pins are oversampled
// in the sys_clk domain (sys_clk must be at least 8x sclk). Received bytes
// are emitted as rx_valid write strobes. Transmit bytes are taken from a
// show-ahead FIFO, and IDLE_BYTE is substituted when that FIFO is empty.
//
// Optional feature, macro SPI_SLAVE_FRAME_CHECK_EN:
//   adds parameter BYTES_PER_FRAME and output frame_err. frame_err pulses
//   together with frame_done when the frame ended on a partial byte, or when
//   the frame held a byte count other than BYTES_PER_FRAME.
//
// Ports:
//   sys_clk      in   system clock
//   aclr         in   asynchronous active-high reset
//   n_cs         in   chip select pin, active low
//   sclk         in   SPI clock pin
//   mosi         in   serial data in, MSB first
//   miso         out  serial data out, MSB first
//   miso_oe      out  miso pad output enable (== busy)
//   tx_data      in   tx FIFO head (show-ahead)
//   tx_empty     in   tx FIFO empty
//   tx_rdreq     out  tx FIFO pop, 1-cycle pulse
//   rx_data      out  last complete received byte
//   rx_valid     out  1-cycle strobe when rx_data updates
//   tx_underrun  out  1-cycle pulse when IDLE_BYTE is substituted
//   busy         out  frame in progress
//   frame_done   out  1-cycle pulse at frame end
//   byte_cnt     out  whole bytes received in the current or last frame
//   frame_err    out  (SPI_SLAVE_FRAME_CHECK_EN only) frame length error
// ---------------------------------------------------------------------------
module spi_slave_byte #(
  parameter logic       CPOL            = 1'b0,
  parameter logic       CPHA            = 1'b0,
  parameter logic [7:0] IDLE_BYTE       = 8'hFF
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  , parameter logic [7:0] BYTES_PER_FRAME = 8'd2
`endif
) (
  input  logic       sys_clk,
  input  logic       aclr,
  input  logic       n_cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rdreq,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] byte_cnt
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  , output logic     frame_err
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // ------------------------------------------------------------------
  // Pin synchronisers. Stage 3 of n_cs/sclk exists only for edge detect.
  // ------------------------------------------------------------------
  logic       ncs_s1, ncs_s2, ncs_s3;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       mosi_s1, mosi_s2;
  logic [1:0] fill_reg;
  logic       armed_reg;

  // The synchroniser preset to "n_cs high" would otherwise look like a
  // falling edge when the pin is already low as reset is released. A frame
  // may only start after n_cs has genuinely been seen high once the
  // synchroniser holds real pin samples (fill_reg == 2).
  always_ff @(posedge sys_clk or posedge aclr) begin
    if (aclr) begin
      ncs_s1    <= 1'b1;
      ncs_s2    <= 1'b1;
      ncs_s3    <= 1'b1;
      sclk_s1   <= CPOL;
      sclk_s2   <= CPOL;
      sclk_s3   <= CPOL;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      fill_reg  <= 2'd0;
      armed_reg <= 1'b0;
    end else begin
      ncs_s1    <= n_cs;
      ncs_s2    <= ncs_s1;
      ncs_s3    <= ncs_s2;
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_s3   <= sclk_s2;
      mosi_s1   <= mosi;
      mosi_s2   <= mosi_s1;
      if (fill_reg != 2'd2) begin
        fill_reg <= fill_reg + 2'd1;
      end
      if ((fill_reg == 2'd2) && ncs_s2) begin
        armed_reg <= 1'b1;
      end
    end
  end

  logic ncs_fall, ncs_rise, sclk_edge, lead, trail, sample_edge, shift_edge;

  assign ncs_fall    = armed_reg & ncs_s3 & ~ncs_s2;
  assign ncs_rise    = ~ncs_s3 & ncs_s2;
  assign sclk_edge   = sclk_s2 ^ sclk_s3;
  assign lead        = sclk_edge & (sclk_s2 != CPOL);
  assign trail       = sclk_edge & (sclk_s2 == CPOL);
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  // ------------------------------------------------------------------
  // Frame state machine and datapath
  // ------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic [6:0] rx_sh_reg, rx_sh_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic [7:0] tx_sh_reg, tx_sh_next;
  logic       first_shift_reg, first_shift_next;
  logic       busy_reg, busy_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_rdreq_reg, tx_rdreq_next;
  logic       tx_underrun_reg, tx_underrun_next;
  logic       frame_done_reg, frame_done_next;
  logic       tx_load;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  logic       frame_err_reg, frame_err_next;
`endif

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    byte_cnt_next    = byte_cnt_reg;
    rx_sh_next       = rx_sh_reg;
    rx_data_next     = rx_data_reg;
    tx_sh_next       = tx_sh_reg;
    first_shift_next = first_shift_reg;
    busy_next        = busy_reg;
    rx_valid_next    = 1'b0;
    tx_rdreq_next    = 1'b0;
    tx_underrun_next = 1'b0;
    frame_done_next  = 1'b0;
    tx_load          = 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    frame_err_next   = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        // sclk edges in this state (including the n_cs fall cycle) are ignored.
        if (ncs_fall) begin
          state_next       = ACTIVE;
          bit_cnt_next     = 3'd0;
          byte_cnt_next    = 8'd0;
          busy_next        = 1'b1;
          first_shift_next = 1'b1;
          // In CPHA=0 the first bit must be on miso before the first edge.
          if (!CPHA) begin
            tx_load = 1'b1;
          end
        end
      end

      ACTIVE: begin
        if (ncs_rise) begin
          // Partial byte is dropped; byte_cnt is kept for the consumer.
          state_next      = IDLE;
          busy_next       = 1'b0;
          frame_done_next = 1'b1;
          bit_cnt_next    = 3'd0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
          frame_err_next  = (bit_cnt_reg != 3'd0) || (byte_cnt_reg != BYTES_PER_FRAME);
`endif
        end else if (!ncs_s2) begin
          if (sample_edge) begin
            rx_sh_next   = {rx_sh_reg[5:0], mosi_s2};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_next  = {rx_sh_reg, mosi_s2};
              rx_valid_next = 1'b1;
              if (byte_cnt_reg != 8'hFF) begin
                byte_cnt_next = byte_cnt_reg + 8'd1;
              end
            end
          end
          if (shift_edge) begin
            first_shift_next = 1'b0;
            // CPHA=0 already loaded at frame start, so its first shift
            // edge never reloads.
            if ((bit_cnt_reg == 3'd0) && (CPHA || !first_shift_reg)) begin
              tx_load = 1'b1;
            end else begin
              tx_sh_next = {tx_sh_reg[6:0], 1'b0};
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase

    if (tx_load) begin
      if (!tx_empty) begin
        tx_sh_next    = tx_data;
        tx_rdreq_next = 1'b1;
      end else begin
        tx_sh_next       = IDLE_BYTE;
        tx_underrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge aclr) begin
    if (aclr) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= 3'd0;
      byte_cnt_reg    <= 8'd0;
      rx_sh_reg       <= 7'd0;
      rx_data_reg     <= 8'd0;
      tx_sh_reg       <= IDLE_BYTE;
      first_shift_reg <= 1'b0;
      busy_reg        <= 1'b0;
      rx_valid_reg    <= 1'b0;
      tx_rdreq_reg    <= 1'b0;
      tx_underrun_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
      frame_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      byte_cnt_reg    <= byte_cnt_next;
      rx_sh_reg       <= rx_sh_next;
      rx_data_reg     <= rx_data_next;
      tx_sh_reg       <= tx_sh_next;
      first_shift_reg <= first_shift_next;
      busy_reg        <= busy_next;
      rx_valid_reg    <= rx_valid_next;
      tx_rdreq_reg    <= tx_rdreq_next;
      tx_underrun_reg <= tx_underrun_next;
      frame_done_reg  <= frame_done_next;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
      frame_err_reg   <= frame_err_next;
`endif
    end
  end

  assign miso        = tx_sh_reg[7];
  assign miso_oe     = busy_reg;
  assign busy        = busy_reg;
  assign tx_rdreq    = tx_rdreq_reg;
  assign tx_underrun = tx_underrun_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign frame_done  = frame_done_reg;
  assign byte_cnt    = byte_cnt_reg;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
  assign frame_err   = frame_err_reg;
`endif

endmodule

// File: doc/spi_slave_byte.md
Name: spi_slave_byte

Overview:
- Byte-oriented SPI slave (responder), the far end of our SPI master links; lets the FPGA be driven by an external SPI master.
- Oversamples the external n_cs/sclk/mosi pins in the sys_clk domain and emits received bytes as write strobes.
- Fetches transmit bytes from a show-ahead FIFO.
- Plugs between pins and dc_fifo pairs exactly as the master side does.

Parameters:
- CPOL, 1'b0, idle sclk level.
- CPHA, 1'b0; 0 = sample on leading edge, 1 = sample on trailing edge.
- IDLE_BYTE, 8'hFF, byte shifted out when the tx FIFO is empty.
- BYTES_PER_FRAME, 8'd2, expected bytes per n_cs frame (used only by the optional check).

Ports:
- sys_clk  in  1  system clock; must run at least 8x the sclk frequency.
- aclr  in  1  asynchronous active-high reset.
- n_cs  in  1  chip select pin, active low.
- sclk  in  1  SPI clock pin.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- miso_oe  out  1  miso output enable for the pad.
- tx_data  in  8  show-ahead FIFO head.
- tx_empty  in  1  tx FIFO empty.
- tx_rdreq  out  1  tx FIFO pop, 1-cycle pulse.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  1-cycle strobe when rx_data updates.
- tx_underrun  out  1  1-cycle pulse when IDLE_BYTE is substituted.
- busy  out  1  frame in progress (synchronised n_cs low).
- frame_done  out  1  1-cycle pulse on frame end.
- byte_cnt  out  8  whole bytes received in the current or last frame.

Behaviour:
- Clocking and reset: single clock, sys_clk; reset is asynchronous and active-high on aclr.
- Reset values: all outputs 0 except the following.
  - miso = IDLE_BYTE[7].
  - tx shift register = IDLE_BYTE.
  - Synchroniser stages preset to idle pin levels: n_cs=1, sclk=CPOL.
- Synchronisers:
  - n_cs, sclk and mosi each pass through 2 flops; a third sclk/n_cs flop provides edge detect.
  - Pin-to-action latency is 3 sys_clk.
- Edge definitions: lead = sclk_s transition away from CPOL; trail = transition back to CPOL.
  - CPHA=0: sample = lead, shift = trail.
  - CPHA=1: sample = trail, shift = lead.
- sclk edges seen while n_cs_s is high are ignored.
- State machine, IDLE:
  - Enters ACTIVE when n_cs_s falls.
  - On entry: bit_cnt=0, byte_cnt=0, busy=1.
  - CPHA=0 only: the first tx byte is loaded in this same cycle.
- State machine, ACTIVE:
  - On each sample edge: rx_sh = {rx_sh[6:0], mosi_s}; bit_cnt = bit_cnt + 1 (3-bit counter, wraps 7 to 0).
  - When the wrap occurs:
    - rx_data = {rx_sh[6:0], mosi_s}.
    - rx_valid pulses for 1 cycle.
    - byte_cnt increments, saturating at 255.
  - On each shift edge:
    - Load if bit_cnt==0; for CPHA=0 the first shift edge of the frame is excluded.
    - Otherwise tx_sh = {tx_sh[6:0], 1'b0}.
- Tx load:
  - tx_empty=0: tx_sh = tx_data, tx_rdreq pulses 1 cycle.
  - tx_empty=1: tx_sh = IDLE_BYTE, tx_underrun pulses, no rdreq.
- miso = tx_sh[7] (registered); miso_oe = busy.
- Frame end: n_cs_s rises, state returns to IDLE.
  - busy=0; frame_done pulses 1 cycle; bit_cnt=0.
  - A partial byte is discarded: no rx_valid.
  - byte_cnt holds its value until the next frame start.
- Simultaneous events:
  - n_cs_s rise in the same cycle as a sample edge: the edge is ignored.
  - n_cs_s fall in the same cycle as an sclk edge: the edge is ignored.
- No rx backpressure: the consumer (FIFO wrreq) must accept every rx_valid.
- aclr asserted mid-frame: immediate return to reset values; the next frame starts only on a fresh n_cs fall.

Optional Feature:
- Macro SPI_SLAVE_FRAME_CHECK_EN.
- When defined: extra output frame_err (1 bit, reset 0).
  - Pulses with frame_done when bit_cnt != 0 at frame end, or byte_cnt != BYTES_PER_FRAME.
  - Check is done before the n_cs fall reset.
- When undefined: port absent; no compare logic.

Test Plan:
- CPOL=0/CPHA=0, tx FIFO {8'hA5,8'h3C}; master sends 8'h12,8'h34 at sys_clk/8 -> rx_valid twice with 8'h12 then 8'h34; miso bits 10100101 00111100; 2 tx_rdreq pulses; byte_cnt=2; frame_done once.
- CPOL=1/CPHA=1, tx FIFO empty; master sends 8'hC3 -> rx_data=8'hC3; miso=8'hFF; tx_underrun 1 pulse; no tx_rdreq.
- Frame aborted after 5 bits -> no rx_valid, byte_cnt=0, frame_done pulses; with SPI_SLAVE_FRAME_CHECK_EN, frame_err=1.
- sclk toggling 16 times with n_cs high -> no rx_valid, no tx_rdreq, miso_oe=0.
- aclr pulsed after 12 bits of a 16-bit frame, n_cs kept low -> outputs at reset values; no activity until n_cs toggles high then low; the next 16-bit frame is received correctly.
- BYTES_PER_FRAME=2, SPI_SLAVE_FRAME_CHECK_EN defined; 3-byte frame -> byte_cnt=3, frame_err pulse; 2-byte frame -> frame_err stays 0.
